// File: rtl/core_fetch_pkg.sv
// rtl/core_fetch_pkg.sv - shared constants, FSM encoding and credit helper for the fetch stage
package core_fetch_pkg;

  // Instruction presented while nothing has been fetched yet (addi x0,x0,0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Prefetch buffer depth; the credit check below is written for two entries
  localparam int FETCH_BUF_DEPTH = 2;

  // Fetch FSM state encodings
  localparam int FETCH_ST_WIDTH = 2;
  localparam logic [FETCH_ST_WIDTH-1:0] FETCH_ST_RESET = 2'd0;
  localparam logic [FETCH_ST_WIDTH-1:0] FETCH_ST_FETCH = 2'd1;
  localparam logic [FETCH_ST_WIDTH-1:0] FETCH_ST_WAIT  = 2'd2;

  typedef enum logic [FETCH_ST_WIDTH-1:0] {
    ST_RESET = FETCH_ST_RESET,
    ST_FETCH = FETCH_ST_FETCH,
    ST_WAIT  = FETCH_ST_WAIT
  } fetch_state_t;

  // A new request may issue only if its eventual data still fits in the
  // buffer: entries left after this cycle plus the one new request <= depth.
  function automatic logic credit_ok(input logic [1:0] count_after);
    return ({1'b0, count_after} + 3'd1) <= 3'd2;
  endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// rtl/core_fetch_fifo.sv - two-entry prefetch buffer of {addr, instr} with registered head
module core_fetch_fifo
  import core_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_instr,
  input  logic                  pop,
  input  logic                  flush,
  output logic [1:0]            count,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_instr,
  output logic                  head_valid
);

  // Second slot; the head slot drives the outputs directly so they are registered
  logic [ADDR_WIDTH-1:0] tail_addr;
  logic [DATA_WIDTH-1:0] tail_instr;
  logic                  do_pop;

  assign do_pop     = pop && (count != 2'd0);
  assign head_valid = (count != 2'd0);

  // Shift-register FIFO: pops move the tail into the head, pushes fill the first free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head_addr  <= '0;
      head_instr <= DATA_WIDTH'(NOP_INSTR);
      tail_addr  <= '0;
      tail_instr <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_addr  <= push_addr;
            head_instr <= push_instr;
            count      <= 2'd1;
          end else if (count == 2'd1) begin
            tail_addr  <= push_addr;
            tail_instr <= push_instr;
            count      <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            head_addr  <= tail_addr;
            head_instr <= tail_instr;
            count      <= 2'd1;
          end else begin
            count <= 2'd0;
          end
        end
        2'b11: begin
          // Count is unchanged; with one entry the new word becomes the head
          if (count == 2'd1) begin
            head_addr  <= push_addr;
            head_instr <= push_instr;
          end else begin
            head_addr  <= tail_addr;
            head_instr <= tail_instr;
            tail_addr  <= push_addr;
            tail_instr <= push_instr;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/core_fetch_unit.sv
// rtl/core_fetch_unit.sv - sequential instruction fetch with 2-entry prefetch and redirect flush
module core_fetch_unit
  import core_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  input  logic                  instr_ack_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_valid_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] ptr;         // next address to request
  logic                  discard;     // the outstanding response belongs to a flushed stream
  logic [1:0]            count;
  logic [1:0]            count_next;
  logic                  mem_hs;
  logic                  push;
  logic                  pop;
  logic                  credit;
  logic [ADDR_WIDTH-1:0] issue_addr;

  // A redirect overrides any push or pop in the same cycle
  assign mem_hs = mem_req_o && mem_ack_i;
  assign push   = mem_hs && !discard && !redirect_i;
  assign pop    = instr_ack_i && instr_valid_o && !redirect_i;

  // Buffer occupancy after this cycle decides whether another request fits
  always_comb begin
    count_next = 2'd0;
    if (!redirect_i) begin
      count_next = count + {1'b0, push} - {1'b0, pop};
    end
    credit     = credit_ok(count_next);
    issue_addr = redirect_i ? redirect_addr_i : ptr;
  end

  // Fetch FSM; owns the registered memory request, the fetch pointer and the discard flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RESET;
      mem_req_o  <= 1'b0;
      mem_addr_o <= RESET_ADDR;
      ptr        <= RESET_ADDR;
      discard    <= 1'b0;
    end else begin
      case (state)
        ST_RESET: begin
          state      <= ST_FETCH;
          mem_req_o  <= 1'b1;
          mem_addr_o <= issue_addr;
          ptr        <= issue_addr + ADDR_ONE;
        end
        ST_FETCH: begin
          if (mem_ack_i) begin
            discard <= 1'b0;
            if (credit) begin
              mem_addr_o <= issue_addr;
              ptr        <= issue_addr + ADDR_ONE;
            end else begin
              state     <= ST_WAIT;
              mem_req_o <= 1'b0;
            end
          end else if (redirect_i) begin
            // Request stays on the bus until acked; its data will be dropped
            discard <= 1'b1;
            ptr     <= redirect_addr_i;
          end
        end
        ST_WAIT: begin
          if (credit) begin
            state      <= ST_FETCH;
            mem_req_o  <= 1'b1;
            mem_addr_o <= issue_addr;
            ptr        <= issue_addr + ADDR_ONE;
          end
        end
        default: begin
          state     <= ST_RESET;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  core_fetch_fifo #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (mem_addr_o),
    .push_instr(mem_rdata_i),
    .pop       (pop),
    .flush     (redirect_i),
    .count     (count),
    .head_addr (instr_addr_o),
    .head_instr(instr_o),
    .head_valid(instr_valid_o)
  );

  assign stall_o = ~instr_valid_o;

endmodule
